// File: rtl/dac_feeder.sv
// dac_feeder: elastic buffer between the synthesis filter and the PWM DAC.
// Incoming 16-bit samples are scaled and saturated to 8 bits and queued in a
// small circular FIFO. Each DAC acknowledge moves the next entry onto dac_din.
// An acknowledge that finds the FIFO empty leaves dac_din at its last value
// and raises a one-cycle underflow pulse.
module dac_feeder #(
  parameter int DEPTH = 4,
  parameter int SHIFT = 6
) (
  input  logic                      clk,
  input  logic                      rst_an,
  input  logic signed [15:0]        sample_in,
  input  logic                      sample_stb,
  output logic                      sample_rdy,
  input  logic                      dac_ack,
  output logic signed [7:0]         dac_din,
  output logic                      underflow,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Floor-shift the filter sample, then clamp it into the signed 8-bit range.
  function automatic logic signed [7:0] scale_sat(input logic signed [15:0] x);
    logic signed [15:0] t;
    t = x >>> SHIFT;
    if (t > 16'sd127)
      return 8'sd127;
    else if (t < -16'sd128)
      return -8'sd128;
    else
      return t[7:0];
  endfunction

  logic signed [7:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              sample_rdy_q, sample_rdy_d;
  logic signed [7:0] dac_din_q, dac_din_d;
  logic              underflow_q, underflow_d;

  logic              wr_en;
  logic              rd_en;
  logic              fifo_empty;
  logic signed [7:0] wr_byte;

  assign fifo_empty = (level_q == '0);
  // sample_rdy is registered, so it alone gates acceptance.
  assign wr_en      = sample_stb & sample_rdy_q;
  assign rd_en      = dac_ack & ~fifo_empty;
  assign wr_byte    = scale_sat(sample_in);

  // Next-state for pointers, level, output byte and status flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    dac_din_d    = dac_din_q;
    underflow_d  = dac_ack & fifo_empty;
    if (wr_en)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      dac_din_d = mem_q[rd_ptr_q];
    end
    if (wr_en && !rd_en)
      level_d = level_q + LVL_W'(1);
    else if (!wr_en && rd_en)
      level_d = level_q - LVL_W'(1);
    sample_rdy_d = (level_d != LVL_W'(DEPTH));
  end

  // Control and output registers; reset returns the DAC to midscale.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sample_rdy_q <= 1'b0;
      dac_din_q    <= '0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sample_rdy_q <= sample_rdy_d;
      dac_din_q    <= dac_din_d;
      underflow_q  <= underflow_d;
    end
  end

  // Sample storage; no reset needed since occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= wr_byte;
  end

  assign sample_rdy = sample_rdy_q;
  assign dac_din    = dac_din_q;
  assign underflow  = underflow_q;
  assign fifo_level = level_q;

endmodule
